pipe_mux: RTL and testbench
===========================

Name: pipe_mux

Overview:
- Parametrised successor to the combinational indexed read mux.
- NPORTS independent read channels share one flattened data array.
- Each channel has a valid/ready request handshake and a registered, back-pressurable response.
- Optional same-cycle write bypass and out-of-range error reporting.
- Sits between the register file / ROB value array and the issue-stage operand collectors.

Parameters:
- WIDTH, 5: index bit width.
- WID, 32: data bit width.
- DEPTH, 1 << WIDTH: number of valid entries. May be less than 2^WIDTH.
- NPORTS, 2: number of independent read channels.
- BYPASS, 1: 1 enables the bypass path; 0 ties it off.

Ports:
- clk_i  input  1  clock. All state updates on the rising edge.
- rst_ni  input  1  synchronous active-low reset.
- data_i  input  WID*DEPTH  flattened array; entry e is at [e*WID +: WID].
- byp_en_i  input  1  bypass write valid this cycle.
- byp_index_i  input  WIDTH  bypass target entry.
- byp_data_i  input  WID  bypass value (newer than data_i).
- req_valid_i  input  NPORTS  per-channel request valid.
- req_ready_o  output  NPORTS  per-channel request ready.
- req_index_i  input  WIDTH*NPORTS  per-channel index; channel p is at [p*WIDTH +: WIDTH].
- resp_valid_o  output  NPORTS  per-channel response valid.
- resp_ready_i  input  NPORTS  per-channel response ready.
- resp_data_o  output  WID*NPORTS  per-channel response data; channel p is at [p*WID +: WID].
- resp_err_o  output  NPORTS  per-channel flag: index was >= DEPTH.

Behaviour:
- Reset: clock-synchronous; rst_ni low at a rising edge clears resp_valid_o, resp_data_o and resp_err_o to 0.
  - Reset mid-operation drops any pending response with no handshake.
  - req_ready_o reads 1 on the cycle after reset release.
- Per-channel state is one response register: valid, data, err. There is no other state. Channels are fully independent; there is no cross-channel arbitration.
- req_ready_o[p] = !resp_valid_o[p] || resp_ready_i[p].
  - Combinational. Must not depend on req_valid_i.
- Accept: req_valid_i[p] && req_ready_o[p] at a rising edge.
  - Next cycle resp_valid_o[p] = 1, carrying the selection below.
  - Latency is exactly 1 cycle. Throughput is 1 request per cycle per channel while resp_ready_i[p] stays high.
- Selection, evaluated at the accept edge:
  1. req_index >= DEPTH: data 0, err 1. Bypass is ignored.
  2. Else if BYPASS = 1, byp_en_i = 1 and byp_index_i == req_index: data = byp_data_i, err 0.
  3. Else: data = data_i[req_index*WID +: WID], err 0.
- Data is sampled at the accept edge. Later changes to data_i or the bypass inputs do not alter a held response.
- Hold: while resp_valid_o[p] && !resp_ready_i[p], resp_data_o and resp_err_o are stable and req_ready_o[p] = 0.
- Response complete: resp_valid_o[p] && resp_ready_i[p].
  - With no accept in the same cycle: resp_valid_o[p] -> 0 next cycle, and data is held (don't-care).
  - With an accept in the same cycle: the register is replaced, resp_valid_o stays 1 with no bubble.
- Multiple channels with the same index in the same cycle all receive identical data.
- A bypass write matching indices on several channels is applied to every matching channel.
- byp_index_i >= DEPTH never matches.
- BYPASS = 0: the byp_* inputs are unused; no logic depends on them.
- Width rules: compare indices at WIDTH bits, unsigned. No truncation of req_index before the DEPTH check.
- No combinational path from req_index_i or data_i to any output.

Test Plan:
1. Reset with DEPTH = 32, NPORTS = 2.
   - Hold rst_ni low for 2 edges with req_valid_i = 2'b11 -> resp_valid_o = 0, resp_data_o = 0, resp_err_o = 0.
   - After release -> req_ready_o = 2'b11.
2. Back-to-back on channel 0, entry e = 0x100 + e, resp_ready_i = 1.
   - Issue indices 3, 7, 31 on consecutive edges -> responses 0x103, 0x107, 0x11F on the following consecutive cycles, no bubbles.
3. Back-pressure on channel 1.
   - Accept index 5, hold resp_ready_i[1] = 0 for 4 cycles, change data_i[5] to 0xDEAD meanwhile -> resp_data_o holds 0x105, req_ready_o[1] = 0 throughout.
   - Raise ready -> a new request is accepted on that same edge.
4. Bypass, BYPASS = 1.
   - Channel 0 index 9 and channel 1 index 9 with byp_en_i = 1, byp_index_i = 9, byp_data_i = 0xCAFE -> both channels respond 0xCAFE.
   - Same with byp_index_i = 8 -> both respond 0x109.
5. Out of range, DEPTH = 20, WIDTH = 5.
   - Request index 25 with bypass on index 25 -> resp_data = 0, resp_err = 1.
   - Next request index 19 -> err 0, data 0x113.
6. Reset mid-operation.
   - Channel 0 stalled with a valid response; assert rst_ni = 0 for 1 edge -> resp_valid_o[0] = 0 next cycle; the dropped response is never presented.

Source files
------------

// File: rtl/pipe_mux_if.sv
// Bus bundle for pipe_mux: shared data array, bypass write and per-channel
// request/response handshakes. The slave modport is the mux side.
interface pipe_mux_if #(
  parameter int WIDTH  = 5,
  parameter int WID    = 32,
  parameter int DEPTH  = 1 << WIDTH,
  parameter int NPORTS = 2
);
  logic [WID*DEPTH-1:0]    data_i;
  logic                    byp_en_i;
  logic [WIDTH-1:0]        byp_index_i;
  logic [WID-1:0]          byp_data_i;
  logic [NPORTS-1:0]       req_valid_i;
  logic [NPORTS-1:0]       req_ready_o;
  logic [WIDTH*NPORTS-1:0] req_index_i;
  logic [NPORTS-1:0]       resp_valid_o;
  logic [NPORTS-1:0]       resp_ready_i;
  logic [WID*NPORTS-1:0]   resp_data_o;
  logic [NPORTS-1:0]       resp_err_o;

  modport master (
    output data_i, byp_en_i, byp_index_i, byp_data_i,
    output req_valid_i, req_index_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_data_o, resp_err_o
  );

  modport slave (
    input  data_i, byp_en_i, byp_index_i, byp_data_i,
    input  req_valid_i, req_index_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_data_o, resp_err_o
  );
endinterface

// File: rtl/pipe_mux.sv
// Multi-channel registered read mux over a flattened data array, with an
// optional same-cycle write bypass and out-of-range error flag per channel.
module pipe_mux #(
  parameter int WIDTH  = 5,
  parameter int WID    = 32,
  parameter int DEPTH  = 1 << WIDTH,
  parameter int NPORTS = 2,
  parameter int BYPASS = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  pipe_mux_if.slave  bus
);

  logic [NPORTS-1:0][WIDTH-1:0] req_idx;
  logic [NPORTS-1:0]            accept;
  logic [NPORTS-1:0]            byp_hit;
  logic [WID-1:0]               byp_value;
  logic [NPORTS-1:0][WID-1:0]   sel_data;
  logic [NPORTS-1:0]            sel_err;

  logic [NPORTS-1:0]            resp_valid_q;
  logic [NPORTS-1:0]            resp_err_q;
  logic [NPORTS-1:0][WID-1:0]   resp_data_q;

  assign req_idx = bus.req_index_i;

  // A slot frees up either when empty or when its response drains this cycle.
  assign bus.req_ready_o  = ~resp_valid_q | bus.resp_ready_i;
  assign accept           = bus.req_valid_i & bus.req_ready_o;
  assign bus.resp_valid_o = resp_valid_q;
  assign bus.resp_err_o   = resp_err_q;
  assign bus.resp_data_o  = resp_data_q;

  if (BYPASS != 0) begin : g_byp
    for (genvar p = 0; p < NPORTS; p++) begin : g_hit
      assign byp_hit[p] = bus.byp_en_i
                        && (bus.byp_index_i == req_idx[p])
                        && (32'(bus.byp_index_i) < DEPTH);
    end
    assign byp_value = bus.byp_data_i;
  end else begin : g_nobyp
    assign byp_hit   = '0;
    assign byp_value = '0;
  end

  always_comb begin
    sel_data = '0;
    sel_err  = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (32'(req_idx[p]) >= DEPTH) begin
        sel_err[p] = 1'b1;
      end else if (byp_hit[p]) begin
        sel_data[p] = byp_value;
      end else begin
        for (int e = 0; e < DEPTH; e++) begin
          if (req_idx[p] == WIDTH'(e)) sel_data[p] = bus.data_i[e*WID +: WID];
        end
      end
    end
  end

  // Data is left untouched on a drain so a completed response costs no toggles.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resp_valid_q <= '0;
      resp_err_q   <= '0;
      resp_data_q  <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (accept[p]) begin
          resp_valid_q[p] <= 1'b1;
          resp_data_q[p]  <= sel_data[p];
          resp_err_q[p]   <= sel_err[p];
        end else if (bus.resp_ready_i[p]) begin
          resp_valid_q[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_mux.sv
// Directed plus random bench for pipe_mux: two instances (DEPTH 32 and 20)
// share one stimulus stream and are checked against a per-channel model.
module tb_pipe_mux;

  localparam int WIDTH  = 5;
  localparam int WID    = 32;
  localparam int NPORTS = 2;
  localparam int NENT   = 32;
  localparam int DEPTH_A = 32;
  localparam int DEPTH_B = 20;

  logic clk;
  logic rst_n;
  logic [WID-1:0]          mem [NENT];
  logic                    byp_en;
  logic [WIDTH-1:0]        byp_idx;
  logic [WID-1:0]          byp_data;
  logic [NPORTS-1:0]       req_valid;
  logic [WIDTH*NPORTS-1:0] req_index;
  logic [NPORTS-1:0]       resp_ready;

  int checks = 0;
  int errors = 0;

  int              depth_of [2] = '{DEPTH_A, DEPTH_B};
  logic            exp_v [2][NPORTS];
  logic            exp_e [2][NPORTS];
  logic [WID-1:0]  exp_d [2][NPORTS];

  pipe_mux_if #(.WIDTH(WIDTH), .WID(WID), .DEPTH(DEPTH_A), .NPORTS(NPORTS)) bus_a ();
  pipe_mux_if #(.WIDTH(WIDTH), .WID(WID), .DEPTH(DEPTH_B), .NPORTS(NPORTS)) bus_b ();

  pipe_mux #(.WIDTH(WIDTH), .WID(WID), .DEPTH(DEPTH_A), .NPORTS(NPORTS), .BYPASS(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_a)
  );
  pipe_mux #(.WIDTH(WIDTH), .WID(WID), .DEPTH(DEPTH_B), .NPORTS(NPORTS), .BYPASS(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus_b)
  );

  always_comb begin
    for (int e = 0; e < DEPTH_A; e++) bus_a.data_i[e*WID +: WID] = mem[e];
    for (int e = 0; e < DEPTH_B; e++) bus_b.data_i[e*WID +: WID] = mem[e];
  end

  assign bus_a.byp_en_i = byp_en;      assign bus_b.byp_en_i = byp_en;
  assign bus_a.byp_index_i = byp_idx;  assign bus_b.byp_index_i = byp_idx;
  assign bus_a.byp_data_i = byp_data;  assign bus_b.byp_data_i = byp_data;
  assign bus_a.req_valid_i = req_valid;  assign bus_b.req_valid_i = req_valid;
  assign bus_a.req_index_i = req_index;  assign bus_b.req_index_i = req_index;
  assign bus_a.resp_ready_i = resp_ready; assign bus_b.resp_ready_i = resp_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [WID-1:0] obsData(int d, int p);
    return (d == 0) ? bus_a.resp_data_o[p*WID +: WID] : bus_b.resp_data_o[p*WID +: WID];
  endfunction
  function automatic logic obsValid(int d, int p);
    return (d == 0) ? bus_a.resp_valid_o[p] : bus_b.resp_valid_o[p];
  endfunction
  function automatic logic obsErr(int d, int p);
    return (d == 0) ? bus_a.resp_err_o[p] : bus_b.resp_err_o[p];
  endfunction
  function automatic logic obsReady(int d, int p);
    return (d == 0) ? bus_a.req_ready_o[p] : bus_b.req_ready_o[p];
  endfunction

  task automatic checkOutput(string tag, logic [WID-1:0] observed, logic [WID-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // A response slot: filled on accept with whatever the index selects at that
  // edge, emptied when the consumer takes it, wiped by reset.
  task automatic updateModel();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NPORTS; p++) begin
        int idx;
        logic free;
        idx  = int'(req_index[p*WIDTH +: WIDTH]);
        free = !exp_v[d][p] || resp_ready[p];
        if (!rst_n) begin
          exp_v[d][p] = 1'b0;
          exp_e[d][p] = 1'b0;
          exp_d[d][p] = '0;
        end else if (req_valid[p] && free) begin
          exp_v[d][p] = 1'b1;
          if (idx >= depth_of[d]) begin
            exp_e[d][p] = 1'b1;
            exp_d[d][p] = '0;
          end else if (byp_en && int'(byp_idx) == idx) begin
            exp_e[d][p] = 1'b0;
            exp_d[d][p] = byp_data;
          end else begin
            exp_e[d][p] = 1'b0;
            exp_d[d][p] = mem[idx];
          end
        end else if (resp_ready[p]) begin
          exp_v[d][p] = 1'b0;
        end
      end
    end
  endtask

  task automatic checkAll();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NPORTS; p++) begin
        checkOutput($sformatf("valid d%0d p%0d", d, p), WID'(obsValid(d, p)), WID'(exp_v[d][p]));
        checkOutput($sformatf("ready d%0d p%0d", d, p), WID'(obsReady(d, p)),
                    WID'(!exp_v[d][p] || resp_ready[p]));
        if (exp_v[d][p]) begin
          checkOutput($sformatf("data d%0d p%0d", d, p), obsData(d, p), exp_d[d][p]);
          checkOutput($sformatf("err d%0d p%0d", d, p), WID'(obsErr(d, p)), WID'(exp_e[d][p]));
        end
      end
    end
  endtask

  task automatic applyStimulus();
    updateModel();
    @(posedge clk);
    #1;
    checkAll();
  endtask

  task automatic setReq(logic [1:0] valid, int idx0, int idx1);
    req_valid = valid;
    req_index[0 +: WIDTH]     = WIDTH'(idx0);
    req_index[WIDTH +: WIDTH] = WIDTH'(idx1);
  endtask

  initial begin
    for (int e = 0; e < NENT; e++) mem[e] = WID'(32'h100 + e);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < NPORTS; p++) begin
        exp_v[d][p] = 1'b0; exp_e[d][p] = 1'b0; exp_d[d][p] = '0;
      end
    byp_en = 1'b0; byp_idx = '0; byp_data = '0;
    resp_ready = 2'b11;
    rst_n = 1'b0;
    setReq(2'b11, 1, 2);
    @(negedge clk);

    $display("[TB] reset");
    applyStimulus();
    applyStimulus();
    checkOutput("reset valid", WID'(bus_a.resp_valid_o), '0);
    checkOutput("reset data", bus_a.resp_data_o[WID-1:0] | bus_a.resp_data_o[2*WID-1:WID], '0);
    checkOutput("reset err", WID'(bus_a.resp_err_o), '0);
    rst_n = 1'b1;
    setReq(2'b00, 0, 0);
    #1;
    checkOutput("ready after release", WID'(bus_a.req_ready_o), WID'(2'b11));

    $display("[TB] back-to-back on channel 0");
    setReq(2'b01, 3, 0);  applyStimulus();
    checkOutput("b2b idx3", obsData(0, 0), 32'h103);
    setReq(2'b01, 7, 0);  applyStimulus();
    checkOutput("b2b idx7", obsData(0, 0), 32'h107);
    setReq(2'b01, 31, 0); applyStimulus();
    checkOutput("b2b idx31", obsData(0, 0), 32'h11F);
    checkOutput("b2b no bubble", WID'(obsValid(0, 0)), 32'd1);
    setReq(2'b00, 0, 0);  applyStimulus();

    $display("[TB] back-pressure on channel 1");
    resp_ready = 2'b01;
    setReq(2'b10, 0, 5); applyStimulus();
    setReq(2'b00, 0, 0);
    mem[5] = 32'hDEAD;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("stall data", obsData(0, 1), 32'h105);
      checkOutput("stall ready", WID'(obsReady(0, 1)), 32'd0);
    end
    resp_ready = 2'b11;
    setReq(2'b10, 0, 6);
    #1;
    checkOutput("drain ready", WID'(obsReady(0, 1)), 32'd1);
    applyStimulus();
    checkOutput("accept on drain", obsData(0, 1), 32'h106);

    $display("[TB] bypass");
    byp_en = 1'b1; byp_idx = 5'd9; byp_data = 32'hCAFE;
    setReq(2'b11, 9, 9); applyStimulus();
    checkOutput("byp ch0", obsData(0, 0), 32'hCAFE);
    checkOutput("byp ch1", obsData(0, 1), 32'hCAFE);
    byp_idx = 5'd8;
    applyStimulus();
    checkOutput("byp miss ch0", obsData(0, 0), 32'h109);
    checkOutput("byp miss ch1", obsData(0, 1), 32'h109);

    $display("[TB] out of range");
    byp_idx = 5'd25; byp_data = 32'hBEEF;
    setReq(2'b01, 25, 0); applyStimulus();
    checkOutput("oor data", obsData(1, 0), 32'h0);
    checkOutput("oor err", WID'(obsErr(1, 0)), 32'd1);
    checkOutput("inrange byp", obsData(0, 0), 32'hBEEF);
    byp_en = 1'b0;
    setReq(2'b01, 19, 0); applyStimulus();
    checkOutput("last entry data", obsData(1, 0), 32'h113);
    checkOutput("last entry err", WID'(obsErr(1, 0)), 32'd0);

    $display("[TB] reset mid-operation");
    resp_ready = 2'b00;
    setReq(2'b01, 4, 0); applyStimulus();
    setReq(2'b00, 0, 0); applyStimulus();
    checkOutput("stalled valid", WID'(obsValid(0, 0)), 32'd1);
    rst_n = 1'b0; applyStimulus();
    checkOutput("mid reset valid", WID'(obsValid(0, 0)), 32'd0);
    rst_n = 1'b1; resp_ready = 2'b11; applyStimulus();
    checkOutput("dropped stays gone", WID'(obsValid(0, 0)), 32'd0);

    $display("[TB] random");
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(63) != 0);
      req_valid  = NPORTS'($urandom);
      req_index  = (WIDTH*NPORTS)'($urandom);
      resp_ready = NPORTS'($urandom);
      byp_en     = 1'($urandom);
      byp_idx    = ($urandom_range(1) != 0) ? req_index[0 +: WIDTH] : WIDTH'($urandom);
      byp_data   = $urandom;
      mem[$urandom_range(NENT-1)] = $urandom;
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
